// File: rtl/behav_updown_counter_pkg.sv
// Shared definitions for the up/down modulo counter.
//   counter_width() : counter width in bits from a byte count
//   DIR_UP/DIR_DOWN : encodings of the up_down input
package behav_updown_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic int counter_width(input int bytes);
    return 8 * bytes;
  endfunction

endpackage

// File: rtl/behav_updown_prescaler.sv
// Modulo-RATIO prescaler producing the counter advance enable.
//   clk     : clock
//   clear   : synchronous active-high reset of the prescaler count
//   restart : synchronous restart (count back to 0), driven by counter load
//   tick    : high in the cycle the count equals RATIO-1 (always high for RATIO=1)
module behav_updown_prescaler #(
  parameter int RATIO = 1
) (
  input  logic clk,
  input  logic clear,
  input  logic restart,
  output logic tick
);

  // One bit minimum so RATIO=1 still has a legal (constant-zero) count.
  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (clear || restart) cnt <= '0;
    else if (tick)        cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/behav_updown_counter.sv
// Loadable up/down modulo counter with programmable limit, step and prescaler.
//   clk     : clock
//   clear   : synchronous active-high reset
//   d       : parallel load value (loaded as-is, even above load_b)
//   load    : synchronous load enable
//   load_b  : modulo limit, highest count value; sampled every cycle
//   up_down : 1 = count up, 0 = count down
//   qd      : registered count
//   qd_b    : terminal-count flag (combinational)
//   qd_c    : one-cycle wrap pulse (carry up / borrow down)
// Edge priority: clear > load > tick > hold.
module behav_updown_counter
  import behav_updown_counter_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int KEEP_WIDTH = 1,
  parameter int HDR_WIDTH  = 1,
  localparam int W = counter_width(DATA_WIDTH)
) (
  input  logic         clk,
  input  logic         clear,
  input  logic [W-1:0] d,
  input  logic         load,
  input  logic [W-1:0] load_b,
  input  logic         up_down,
  output logic [W-1:0] qd,
  output logic         qd_b,
  output logic         qd_c
);

  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $fatal(1, "DATA_WIDTH must be >= 1");
  end
  if (KEEP_WIDTH < 1 || (W < 31 && KEEP_WIDTH >= (1 << W))) begin : g_bad_keep_width
    $fatal(1, "KEEP_WIDTH must satisfy 1 <= KEEP_WIDTH < 2^W");
  end
  if (HDR_WIDTH < 1) begin : g_bad_hdr_width
    $fatal(1, "HDR_WIDTH must be >= 1");
  end

  localparam logic [W-1:0] STEP = W'(KEEP_WIDTH);

  logic         tick;
  logic [W:0]   sum_up;
  logic         wrap_up;
  logic         wrap_dn;
  logic [W-1:0] qd_nxt;
  logic         qd_c_nxt;

  behav_updown_prescaler #(
    .RATIO (HDR_WIDTH)
  ) u_presc (
    .clk     (clk),
    .clear   (clear),
    .restart (load),
    .tick    (tick)
  );

  // Up-compare done one bit wider so qd+S never aliases past load_b.
  assign sum_up  = {1'b0, qd} + {1'b0, STEP};
  assign wrap_up = (sum_up > {1'b0, load_b});
  assign wrap_dn = (qd < STEP);

  always_comb begin
    qd_nxt   = qd;
    qd_c_nxt = 1'b0;
    if (tick) begin
      if (up_down == DIR_UP) begin
        qd_nxt   = wrap_up ? '0 : sum_up[W-1:0];
        qd_c_nxt = wrap_up;
      end else begin
        qd_nxt   = wrap_dn ? load_b : (qd - STEP);
        qd_c_nxt = wrap_dn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      qd   <= '0;
      qd_c <= 1'b0;
    end else if (load) begin
      qd   <= d;
      qd_c <= 1'b0;
    end else begin
      qd   <= qd_nxt;
      qd_c <= qd_c_nxt;
    end
  end

  assign qd_b = (up_down == DIR_UP) ? (qd >= load_b) : (qd == '0);

endmodule

// File: tb/tb_behav_updown_counter.sv
module tb_behav_updown_counter;

  logic       clk = 1'b0;
  logic       clear, load, up_down;
  logic [7:0] d, load_b;
  logic [7:0] qd, qd2;
  logic       qd_b, qd_c, qd_b2, qd_c2;
  int         passed = 0;
  int         total  = 0;

  always #5 clk = ~clk;

  // Default instance: step 1, no prescaling.
  behav_updown_counter dut (
    .clk(clk), .clear(clear), .d(d), .load(load), .load_b(load_b),
    .up_down(up_down), .qd(qd), .qd_b(qd_b), .qd_c(qd_c)
  );

  // Step 3, advance every 4th clock. Shares the inputs of the default instance.
  behav_updown_counter #(.DATA_WIDTH(1), .KEEP_WIDTH(3), .HDR_WIDTH(4)) dut2 (
    .clk(clk), .clear(clear), .d(d), .load(load), .load_b(load_b),
    .up_down(up_down), .qd(qd2), .qd_b(qd_b2), .qd_c(qd_c2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1; load = $urandom_range(0, 1); up_down = 1'b0;
    d = 8'($urandom); load_b = 8'($urandom);
    cyc();
    d = 8'($urandom); load_b = 8'($urandom); load = $urandom_range(0, 1);
    cyc();
    total++;
    if (qd !== 8'd0 || qd_c !== 1'b0 || qd_b !== 1'b1) begin
      $display("FAIL reset: qd=%0d qd_c=%b qd_b=%b, want 0 0 1", qd, qd_c, qd_b);
    end else passed++;
    total++;
    if (qd2 !== 8'd0 || qd_c2 !== 1'b0 || qd_b2 !== 1'b1) begin
      $display("FAIL reset_presc: qd=%0d qd_c=%b qd_b=%b, want 0 0 1", qd2, qd_c2, qd_b2);
    end else passed++;
    load = 1'b0;
  endtask

  task automatic test_up_wrap();
    logic [7:0] exp_q [6] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0};
    logic       exp_c [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       exp_b [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    clear = 1'b1; load = 1'b0; cyc();
    clear = 1'b0; load_b = 8'd5; up_down = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      total++;
      if (qd !== exp_q[i] || qd_c !== exp_c[i] || qd_b !== exp_b[i]) begin
        $display("FAIL up_wrap[%0d]: qd=%0d qd_c=%b qd_b=%b, want %0d %b %b",
                 i, qd, qd_c, qd_b, exp_q[i], exp_c[i], exp_b[i]);
      end else passed++;
    end
  endtask

  task automatic test_down_wrap();
    logic [7:0] exp_q [4] = '{8'd0, 8'd3, 8'd2, 8'd1};
    logic       exp_c [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp_b [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    load_b = 8'd3; d = 8'd1; load = 1'b1; up_down = 1'b0;
    cyc();
    total++;
    if (qd !== 8'd1 || qd_c !== 1'b0) begin
      $display("FAIL down_load: qd=%0d qd_c=%b, want 1 0", qd, qd_c);
    end else passed++;
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++;
      if (qd !== exp_q[i] || qd_c !== exp_c[i] || qd_b !== exp_b[i]) begin
        $display("FAIL down_wrap[%0d]: qd=%0d qd_c=%b qd_b=%b, want %0d %b %b",
                 i, qd, qd_c, qd_b, exp_q[i], exp_c[i], exp_b[i]);
      end else passed++;
    end
  endtask

  task automatic test_load_priority();
    d = 8'hA7; load = 1'b1; clear = 1'b1; up_down = 1'b1; load_b = 8'hFF;
    cyc();
    total++;
    if (qd !== 8'd0 || qd2 !== 8'd0) begin
      $display("FAIL clear_over_load: qd=%0h qd2=%0h, want 0 0", qd, qd2);
    end else passed++;
    clear = 1'b0;
    cyc();
    total++;
    if (qd !== 8'hA7 || qd_c !== 1'b0 || qd2 !== 8'hA7) begin
      $display("FAIL load: qd=%0h qd_c=%b qd2=%0h, want a7 0 a7", qd, qd_c, qd2);
    end else passed++;
    load = 1'b0;
    cyc();
    total++;
    if (qd !== 8'hA8) begin
      $display("FAIL load_then_up: qd=%0h, want a8", qd);
    end else passed++;
    // Prescaler restarted by load: three holds, then advance by 3.
    cyc(); cyc();
    total++;
    if (qd2 !== 8'hA7 || qd_c2 !== 1'b0) begin
      $display("FAIL presc_restart_hold: qd2=%0h qd_c2=%b, want a7 0", qd2, qd_c2);
    end else passed++;
    cyc();
    total++;
    if (qd2 !== 8'hAA) begin
      $display("FAIL presc_restart_tick: qd2=%0h, want aa", qd2);
    end else passed++;
  endtask

  task automatic test_load_above_limit();
    load_b = 8'd10; d = 8'd200; load = 1'b1; up_down = 1'b1;
    cyc();
    load = 1'b0;
    cyc();
    total++;
    if (qd !== 8'd0 || qd_c !== 1'b1) begin
      $display("FAIL above_up: qd=%0d qd_c=%b, want 0 1", qd, qd_c);
    end else passed++;
    load = 1'b1; up_down = 1'b0;
    cyc();
    load = 1'b0;
    cyc();
    total++;
    if (qd !== 8'd199 || qd_c !== 1'b0) begin
      $display("FAIL above_down: qd=%0d qd_c=%b, want 199 0", qd, qd_c);
    end else passed++;
  endtask

  task automatic test_zero_limit();
    clear = 1'b1; cyc();
    clear = 1'b0; load_b = 8'd0; up_down = 1'b1;
    total++;
    if (qd_b !== 1'b1) begin
      $display("FAIL zero_limit_tc: qd_b=%b, want 1", qd_b);
    end else passed++;
    for (int i = 0; i < 2; i++) begin
      cyc();
      total++;
      if (qd !== 8'd0 || qd_c !== 1'b1) begin
        $display("FAIL zero_up[%0d]: qd=%0d qd_c=%b, want 0 1", i, qd, qd_c);
      end else passed++;
    end
    up_down = 1'b0;
    cyc();
    total++;
    if (qd !== 8'd0 || qd_c !== 1'b1 || qd_b !== 1'b1) begin
      $display("FAIL zero_down: qd=%0d qd_c=%b qd_b=%b, want 0 1 1", qd, qd_c, qd_b);
    end else passed++;
  endtask

  task automatic test_step_prescaler();
    // 24 clocks: ticks land on clocks 4,8,...; direction down for tick 3 only.
    logic [7:0] exp_q [6] = '{8'd3, 8'd6, 8'd3, 8'd6, 8'd9, 8'd0};
    logic       exp_c [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    clear = 1'b1; cyc();
    clear = 1'b0; load_b = 8'd10; up_down = 1'b1;
    for (int t = 0; t < 6; t++) begin
      up_down = (t == 2) ? 1'b0 : 1'b1;
      for (int k = 0; k < 3; k++) begin
        cyc();
        total++;
        if (qd_c2 !== 1'b0 || qd2 !== ((t == 0) ? 8'd0 : exp_q[t-1])) begin
          $display("FAIL step_hold[%0d.%0d]: qd=%0d qd_c=%b, want %0d 0",
                   t, k, qd2, qd_c2, (t == 0) ? 8'd0 : exp_q[t-1]);
        end else passed++;
      end
      cyc();
      total++;
      if (qd2 !== exp_q[t] || qd_c2 !== exp_c[t]) begin
        $display("FAIL step_tick[%0d]: qd=%0d qd_c=%b, want %0d %b",
                 t, qd2, qd_c2, exp_q[t], exp_c[t]);
      end else passed++;
    end
    cyc();
    total++;
    if (qd_c2 !== 1'b0) begin
      $display("FAIL step_pulse_len: qd_c=%b, want 0", qd_c2);
    end else passed++;
  endtask

  initial begin
    clear = 1'b1; load = 1'b0; up_down = 1'b0; d = '0; load_b = '0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_priority();
    test_load_above_limit();
    test_zero_limit();
    test_step_prescaler();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
